l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/torrence_types.sv | 39 +++
 rtl/l2_arbiter_if.sv | 46 ++++
 rtl/l2_hold_watchdog.sv | 44 ++++
 rtl/l2_arbiter.sv | 101 ++++++++++
 tb/tb_l2_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/torrence_types.sv
// Shared types for the L2 path: memory operations, arbiter state encoding and
// requester identity, plus the arbitration pick used by the L2 arbiter.
package torrence_types;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    CLFLUSH    = 2'd2,
    MO_UNKNOWN = 2'd3
  } memory_operation_e;

  // Plain vector plus constants so illegal encodings (2'b11) stay representable.
  typedef logic [1:0] arb_state_e;
  localparam arb_state_e ST_IDLE     = 2'd0;
  localparam arb_state_e ST_GRANT_IC = 2'd1;
  localparam arb_state_e ST_GRANT_DC = 2'd2;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } requester_e;

  // On a tie the requester that was not granted last time wins.
  function automatic arb_state_e pick_grant(input logic ic_valid,
                                            input logic dc_valid,
                                            input requester_e last_grant);
    arb_state_e pick;
    pick = ST_IDLE;
    if (ic_valid && dc_valid) begin
      pick = (last_grant == REQ_IC) ? ST_GRANT_DC : ST_GRANT_IC;
    end else if (ic_valid) begin
      pick = ST_GRANT_IC;
    end else if (dc_valid) begin
      pick = ST_GRANT_DC;
    end
    return pick;
  endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of icache, dcache and L2 request/completion signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
import torrence_types::*;

interface l2_arbiter_if #(parameter int XLEN = 32);

  logic              ic_req_valid;
  memory_operation_e ic_req_type;
  logic [XLEN-1:0]   ic_req_address;
  logic              ic_req_fulfilled;

  logic              dc_req_valid;
  memory_operation_e dc_req_type;
  logic [XLEN-1:0]   dc_req_address;
  logic [XLEN-1:0]   dc_req_store_word;
  logic              dc_req_fulfilled;

  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [XLEN-1:0]   l2_req_address;
  logic [XLEN-1:0]   l2_req_store_word;
  logic              l2_req_fulfilled;

  logic              arb_error;

  modport master (
    input  ic_req_valid, ic_req_type, ic_req_address,
    output ic_req_fulfilled,
    input  dc_req_valid, dc_req_type, dc_req_address, dc_req_store_word,
    output dc_req_fulfilled,
    output l2_req_valid, l2_req_type, l2_req_address, l2_req_store_word,
    input  l2_req_fulfilled,
    output arb_error
  );

  modport slave (
    output ic_req_valid, ic_req_type, ic_req_address,
    input  ic_req_fulfilled,
    output dc_req_valid, dc_req_type, dc_req_address, dc_req_store_word,
    input  dc_req_fulfilled,
    input  l2_req_valid, l2_req_type, l2_req_address, l2_req_store_word,
    output l2_req_fulfilled,
    input  arb_error
  );

endinterface

// File: rtl/l2_hold_watchdog.sv
// Counts how long a single grant has been held and raises a sticky error once
// the count reaches MAX_HOLD_CYCLES.
module l2_hold_watchdog #(
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_entry,
  input  logic granted,
  output logic arb_error
);

  localparam int CW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD_CYCLES);

  logic [CW-1:0] hold_count_reg;
  logic [CW-1:0] hold_count_next;
  logic          arb_error_reg;

  always_comb begin
    hold_count_next = hold_count_reg;
    if (grant_entry) begin
      hold_count_next = '0;
    end else if (granted && (hold_count_reg != HOLD_MAX)) begin
      hold_count_next = hold_count_reg + 1'b1;
    end
  end

  // Error is keyed off the next count so it rises on the same edge the count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_count_reg <= '0;
      arb_error_reg  <= 1'b0;
    end else begin
      hold_count_reg <= hold_count_next;
      if (hold_count_next == HOLD_MAX) begin
        arb_error_reg <= 1'b1;
      end
    end
  end

  assign arb_error = arb_error_reg;

endmodule

// File: rtl/l2_arbiter.sv
// Two-requester L2 arbiter: icache and dcache share one L2 port. A grant is held
// for the whole block transfer and handed off directly when the owner releases.
module l2_arbiter
  import torrence_types::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input logic         clk,
  input logic         reset,
  l2_arbiter_if.master bus
);

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  arb_state_e state_reg;
  arb_state_e state_next;
  requester_e last_grant_reg;
  logic       grant_entry;
  logic       granted;
  logic       arb_error;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:
        state_next = pick_grant(bus.ic_req_valid, bus.dc_req_valid, last_grant_reg);
      ST_GRANT_IC:
        if (!bus.ic_req_valid)
          state_next = pick_grant(1'b0, bus.dc_req_valid, last_grant_reg);
      ST_GRANT_DC:
        if (!bus.dc_req_valid)
          state_next = pick_grant(bus.ic_req_valid, 1'b0, last_grant_reg);
      default:
        state_next = 'x;
    endcase
  end

  // A handoff never re-enters the same grant, so any change into a grant state is an entry.
  assign grant_entry = ((state_next == ST_GRANT_IC) || (state_next == ST_GRANT_DC)) &&
                       (state_next != state_reg);
  assign granted     = (state_reg == ST_GRANT_IC) || (state_reg == ST_GRANT_DC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= REQ_IC;
    end else begin
      state_reg <= state_next;
      if (grant_entry) begin
        last_grant_reg <= (state_next == ST_GRANT_DC) ? REQ_DC : REQ_IC;
      end
    end
  end

  always_comb begin
    bus.l2_req_valid      = 1'b0;
    bus.l2_req_type       = LOAD;
    bus.l2_req_address    = ZERO_WORD;
    bus.l2_req_store_word = ZERO_WORD;
    bus.ic_req_fulfilled  = 1'b0;
    bus.dc_req_fulfilled  = 1'b0;
    case (state_reg)
      ST_IDLE: ;
      ST_GRANT_IC: begin
        bus.l2_req_valid     = bus.ic_req_valid;
        bus.l2_req_type      = bus.ic_req_type;
        bus.l2_req_address   = bus.ic_req_address;
        bus.ic_req_fulfilled = bus.l2_req_fulfilled;
      end
      ST_GRANT_DC: begin
        bus.l2_req_valid      = bus.dc_req_valid;
        bus.l2_req_type       = bus.dc_req_type;
        bus.l2_req_address    = bus.dc_req_address;
        bus.l2_req_store_word = bus.dc_req_store_word;
        bus.dc_req_fulfilled  = bus.l2_req_fulfilled;
      end
      default: begin
        bus.l2_req_valid      = 1'bx;
        bus.l2_req_type       = memory_operation_e'('x);
        bus.l2_req_address    = 'x;
        bus.l2_req_store_word = 'x;
        bus.ic_req_fulfilled  = 1'bx;
        bus.dc_req_fulfilled  = 1'bx;
      end
    endcase
  end

  l2_hold_watchdog #(
    .MAX_HOLD_CYCLES(MAX_HOLD_CYCLES)
  ) u_hold_watchdog (
    .clk        (clk),
    .reset      (reset),
    .grant_entry(grant_entry),
    .granted    (granted),
    .arb_error  (arb_error)
  );

  assign bus.arb_error = arb_error;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: cycle vector table for grant/handoff
// behaviour, scoreboarded tie alternation, hold watchdog and async reset.
module tb_l2_arbiter;
  import torrence_types::*;

  localparam logic [31:0] IC_ADDR  = 32'h1000_0040;
  localparam logic [31:0] DC_ADDR  = 32'h2000_0080;
  localparam logic [31:0] DC_STORE = 32'hDEAD_BEEF;

  typedef struct {
    logic              ic_v;
    logic              dc_v;
    logic              l2_f;
    logic              exp_v;
    memory_operation_e exp_type;
    logic [31:0]       exp_addr;
    logic [31:0]       exp_store;
    logic              exp_ic_f;
    logic              exp_dc_f;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];
  requester_e exp_q[$];
  requester_e last_model;

  l2_arbiter_if #(.XLEN(32)) bus ();

  l2_arbiter #(.XLEN(32), .MAX_HOLD_CYCLES(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [69:0] observed();
    return {bus.l2_req_valid, bus.l2_req_type, bus.l2_req_address, bus.l2_req_store_word,
            bus.ic_req_fulfilled, bus.dc_req_fulfilled, bus.arb_error};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic ic_v, input logic dc_v, input logic l2_f,
                         input logic ev, input memory_operation_e et,
                         input logic [31:0] ea, input logic [31:0] es,
                         input logic eif, input logic edf);
    vec_t v;
    v.ic_v = ic_v; v.dc_v = dc_v; v.l2_f = l2_f;
    v.exp_v = ev; v.exp_type = et; v.exp_addr = ea; v.exp_store = es;
    v.exp_ic_f = eif; v.exp_dc_f = edf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ic_v, input logic dc_v, input logic l2_f);
    bus.ic_req_valid     = ic_v;
    bus.dc_req_valid     = dc_v;
    bus.l2_req_fulfilled = l2_f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.ic_req_type       = LOAD;
    bus.ic_req_address    = IC_ADDR;
    bus.dc_req_type       = STORE;
    bus.dc_req_address    = DC_ADDR;
    bus.dc_req_store_word = DC_STORE;
    drive(1'b0, 1'b0, 1'b0);

    // Tie from reset goes to dcache; 4-word dcache fill then direct handoff to icache.
    //      ic  dc  f   v   type   addr     store     icf dcf
    add_vec(1, 1, 1, 0, LOAD,  32'h0,   32'h0,    0, 0);
    add_vec(1, 1, 1, 1, STORE, DC_ADDR, DC_STORE, 0, 1);
    add_vec(1, 1, 0, 1, STORE, DC_ADDR, DC_STORE, 0, 0);
    add_vec(1, 1, 1, 1, STORE, DC_ADDR, DC_STORE, 0, 1);
    add_vec(1, 1, 0, 1, STORE, DC_ADDR, DC_STORE, 0, 0);
    add_vec(1, 1, 1, 1, STORE, DC_ADDR, DC_STORE, 0, 1);
    add_vec(1, 1, 1, 1, STORE, DC_ADDR, DC_STORE, 0, 1);
    add_vec(1, 0, 0, 0, STORE, DC_ADDR, DC_STORE, 0, 0);
    add_vec(1, 0, 1, 1, LOAD,  IC_ADDR, 32'h0,    1, 0);
    add_vec(1, 1, 0, 1, LOAD,  IC_ADDR, 32'h0,    0, 0);
    add_vec(0, 1, 1, 0, LOAD,  IC_ADDR, 32'h0,    1, 0);
    add_vec(0, 1, 0, 1, STORE, DC_ADDR, DC_STORE, 0, 0);
    add_vec(0, 0, 1, 0, STORE, DC_ADDR, DC_STORE, 0, 1);
    add_vec(0, 0, 1, 0, LOAD,  32'h0,   32'h0,    0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observed(), 70'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ic_v, vecs[i].dc_v, vecs[i].l2_f);
      #1;
      check($sformatf("vec%0d", i), observed(),
            {vecs[i].exp_v, vecs[i].exp_type, vecs[i].exp_addr, vecs[i].exp_store,
             vecs[i].exp_ic_f, vecs[i].exp_dc_f, 1'b0});
      $display("vec %0d: l2_valid=%0b addr=%h ic_f=%0b dc_f=%0b", i,
               bus.l2_req_valid, bus.l2_req_address, bus.ic_req_fulfilled, bus.dc_req_fulfilled);
      next_cycle();
    end

    // Tie alternation: the last entry in the table above was a dcache grant.
    last_model = REQ_DC;
    for (int t = 0; t < 6; t++) begin
      drive(1'b1, 1'b1, 1'b0);
      last_model = (last_model == REQ_IC) ? REQ_DC : REQ_IC;
      exp_q.push_back(last_model);
      next_cycle();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL alt%0d: got empty scoreboard expected one entry", t);
      end else begin
        requester_e w;
        w = exp_q.pop_front();
        check($sformatf("alt%0d_grant", t),
              {37'h0, bus.l2_req_valid, bus.l2_req_address},
              {37'h0, 1'b1, (w == REQ_IC) ? IC_ADDR : DC_ADDR});
        $display("txn %0d: granted addr=%h", t, bus.l2_req_address);
      end
      drive(1'b0, 1'b0, 1'b0);
      next_cycle();
      check($sformatf("alt%0d_idle", t), {69'h0, bus.l2_req_valid}, 70'h0);
    end

    // Hold watchdog: icache keeps valid for the whole saturation window.
    drive(1'b1, 1'b0, 1'b0);
    next_cycle();
    check("wd_entry", {68'h0, bus.l2_req_valid, bus.arb_error}, {68'h0, 2'b10});
    repeat (63) next_cycle();
    check("wd_63_cycles", {69'h0, bus.arb_error}, 70'h0);
    next_cycle();
    check("wd_64_cycles", {69'h0, bus.arb_error}, 70'h1);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) next_cycle();
    check("wd_sticky", {68'h0, bus.l2_req_valid, bus.arb_error}, {68'h0, 2'b01});
    $display("watchdog: arb_error=%0b", bus.arb_error);

    // Asynchronous reset in the middle of an icache grant.
    drive(1'b1, 1'b0, 1'b0);
    next_cycle();
    check("rst_pre_grant", {69'h0, bus.l2_req_valid}, 70'h1);
    #2;
    reset = 1'b1;
    bus.l2_req_fulfilled = 1'b1;
    #1;
    check("rst_async", {67'h0, bus.l2_req_valid, bus.ic_req_fulfilled, bus.arb_error},
          70'h0);
    next_cycle();
    check("rst_held", {67'h0, bus.ic_req_fulfilled, bus.dc_req_fulfilled, bus.l2_req_valid},
          70'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    #1;
    check("idle_fulfilled", {67'h0, bus.ic_req_fulfilled, bus.dc_req_fulfilled,
                             bus.l2_req_valid}, 70'h0);
    next_cycle();
    check("idle_after_rst", {67'h0, bus.ic_req_fulfilled, bus.dc_req_fulfilled,
                             bus.l2_req_valid}, 70'h0);
    $display("reset: l2_valid=%0b arb_error=%0b", bus.l2_req_valid, bus.arb_error);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
